// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end feeding iDecode.
//   Holds the PC, issues reads to a 1-cycle-latency instruction memory, buffers the
//   returned words with their PCs in a QDEPTH-entry FIFO and presents the head to decode
//   with a valid/ready handshake. A redirect restarts fetch at redirect_pc and flushes
//   every buffered and in-flight word.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   imem_req/imem_addr   fetch request and byte address (word aligned)
//   imem_rdata           instruction word returned the cycle after imem_req
//   redirect/redirect_pc branch redirect and its target (bits [1:0] ignored)
//   instr_valid/ready    decode handshake on the FIFO head
//   instr/instr_pc       FIFO head word and its PC
// Optional feature: define IFETCH_PERF_EN to add perf_fetched / perf_flushed counters.
module ifetch_queue #(
    parameter int unsigned QDEPTH   = 4,
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed,
`endif
    output logic [63:0] instr_pc
);

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned SUM_W   = CNT_W + 1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [WORD_W-1:0]  pc;
    } entry_t;

    entry_t             fifo_q [QDEPTH];
    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [WORD_W-1:0]  tag_pc_q, tag_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               inflight_q, inflight_d;

    logic [SUM_W-1:0]   credit_c;
    logic               push_c;
    logic               pop_c;
    logic               unused_lsb_c;

    // Target low bits are dropped; the PC is always word aligned.
    assign unused_lsb_c = ^redirect_pc[1:0];

    // Credits cover buffered entries plus the one word that may still be returning.
    assign credit_c    = SUM_W'(cnt_q) + SUM_W'(inflight_q);
    assign imem_req    = rst_n & ~redirect & (credit_c < SUM_W'(QDEPTH));
    assign imem_addr   = pc_q;
    assign instr_valid = rst_n & (cnt_q != '0);
    assign instr       = fifo_q[rd_ptr_q].instr;
    assign instr_pc    = fifo_q[rd_ptr_q].pc;
    assign push_c      = inflight_q & ~redirect;
    assign pop_c       = instr_valid & instr_ready & ~redirect;

    // Next-state for PC, pointers, occupancy and in-flight tracking.
    always_comb begin
        pc_d       = pc_q;
        tag_pc_d   = tag_pc_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = 1'b0;

        if (redirect) begin
            pc_d     = {redirect_pc[WORD_W-1:2], 2'b00};
            cnt_d    = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (imem_req) begin
                pc_d       = pc_q + WORD_W'(4);
                tag_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
            if (push_c) begin
                wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (pop_c) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            case ({push_c, pop_c})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= {PC_RESET[WORD_W-1:2], 2'b00};
            tag_pc_q   <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_pc_q   <= tag_pc_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    // FIFO storage; contents are qualified by cnt_q so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{instr: imem_rdata, pc: tag_pc_q};
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    // Flushed count includes a return discarded by the same redirect.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push_c);
        perf_flushed_d = perf_flushed_q;
        if (redirect) begin
            perf_flushed_d = perf_flushed_q + 32'(cnt_q) + 32'(inflight_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: reset, streaming, back-pressure, redirects,
// redirect colliding with an in-flight return, reset while full, PC wrap.
module tb_ifetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int n_checks;
    int n_errors;

    ifetch_queue #(.QDEPTH(4), .PC_RESET(64'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
`ifdef IFETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
`endif
        .instr_pc    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents.
    function automatic logic [31:0] imem_word(input logic [63:0] a);
        case (a)
            64'h0:   imem_word = 32'hF84402C9;
            64'h4:   imem_word = 32'h8B0902A9;
            64'h8:   imem_word = 32'hCB0A028B;
            default: imem_word = 32'hE0000000 | 32'(a[27:0]);
        endcase
    endfunction

    // 1-cycle-latency memory.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lands 2 time units after the next rising edge; inputs are driven there.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_head(input string tag, input logic [63:0] pc);
        check({tag, "_valid"}, 64'(instr_valid), 64'd1);
        check({tag, "_pc"}, instr_pc, pc);
        check({tag, "_instr"}, 64'(instr), 64'(imem_word(pc)));
    endtask

    // One reset edge; returns in the first post-reset cycle with rst_n released.
    task automatic do_reset(input logic rdy);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        instr_ready = rdy;
        #1;
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        instr_ready = 1'b0;
        imem_rdata  = 32'h0;

        // Reset held for two edges.
        #2;
        next_cycle();
        #1;
        check("rst1_req", 64'(imem_req), 64'd0);
        check("rst1_valid", 64'(instr_valid), 64'd0);
        next_cycle();
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        #1;
        check("rel_req", 64'(imem_req), 64'd1);
        check("rel_addr", imem_addr, 64'h0);
        check("rel_valid", 64'(instr_valid), 64'd0);

        // Streaming: first valid two cycles after first request, then one per cycle.
        next_cycle();
        #1;
        check("lat_valid", 64'(instr_valid), 64'd0);
        check("lat_addr", imem_addr, 64'h4);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check_head("stream", 64'(4 * i));
        end
`ifdef IFETCH_PERF_EN
        check("perf_fetched_stream", 64'(perf_fetched), 64'd3);
`endif

        // Redirect at head pc=8 with ready high and an in-flight return for 0xC.
        redirect    = 1'b1;
        redirect_pc = 64'h43;
        #1;
        check("redir_req", 64'(imem_req), 64'd0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("redir_valid0", 64'(instr_valid), 64'd0);
        check("redir_req_tgt", 64'(imem_req), 64'd1);
        check("redir_addr", imem_addr, 64'h40);
`ifdef IFETCH_PERF_EN
        check("perf_flushed_redir", 64'(perf_flushed), 64'd2);
`endif
        next_cycle();
        #1;
        check("redir_valid1", 64'(instr_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #1;
            check_head("tgt", 64'h40 + 64'(4 * i));
        end

        // Back-pressure: ready low for 10 cycles fills the FIFO.
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) next_cycle();
        #1;
        check_head("full_head", 64'h0);
        check("full_req", 64'(imem_req), 64'd0);
        check("full_addr", imem_addr, 64'h10);
        instr_ready = 1'b1;
        #1;
        check("full_req_pop", 64'(imem_req), 64'd0);
        for (int i = 0; i < 6; i++) begin
            check_head("drain", 64'(4 * i));
            next_cycle();
            #1;
        end

        // Reset while the FIFO is full.
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) next_cycle();
        #1;
        check("full2_req", 64'(imem_req), 64'd0);
`ifdef IFETCH_PERF_EN
        check("perf_fetched_full", 64'(perf_fetched), 64'd4);
`endif
        do_reset(1'b0);
        #1;
        check("rst_full_valid", 64'(instr_valid), 64'd0);
        check("rst_full_req", 64'(imem_req), 64'd1);
        check("rst_full_addr", imem_addr, 64'h0);
`ifdef IFETCH_PERF_EN
        check("rst_perf_fetched", 64'(perf_fetched), 64'd0);
        check("rst_perf_flushed", 64'(perf_flushed), 64'd0);
`endif

        // Redirect with count=2, in-flight return and ready high in the same cycle.
        next_cycle();
        next_cycle();
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        instr_ready = 1'b1;
        #1;
        check("rp_req", 64'(imem_req), 64'd0);
        check_head("rp_head", 64'h0);
`ifdef IFETCH_PERF_EN
        check("rp_perf_fetched", 64'(perf_fetched), 64'd2);
`endif
        next_cycle();
        redirect = 1'b0;
        #1;
        check("rp_valid", 64'(instr_valid), 64'd0);
        check("rp_addr", imem_addr, 64'h100);
`ifdef IFETCH_PERF_EN
        check("rp_perf_flushed", 64'(perf_flushed), 64'd3);
`endif
        next_cycle();
        #1;
        check("rp_valid1", 64'(instr_valid), 64'd0);
        next_cycle();
        #1;
        check_head("rp_tgt", 64'h100);

        // PC wraps at 2^64.
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        next_cycle();
        redirect = 1'b0;
        #1;
        check("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        next_cycle();
        #1;
        check("wrap_addr1", imem_addr, 64'h0);
        check("wrap_req", 64'(imem_req), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
